// File: rtl/banked_shared_memory_if.sv
// rtl/banked_shared_memory_if.sv - request/response bundle for the banked shared memory
interface banked_shared_memory_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            resp_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] resp_rdata;
    logic [CNT_WIDTH-1:0]            conflict_count;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, conflict_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, conflict_count
    );
endinterface

// File: rtl/banked_shared_memory.sv
// rtl/banked_shared_memory.sv - word-interleaved multi-bank scratchpad with per-bank round-robin arbitration
module banked_shared_memory #(
    parameter int NUM_PORTS  = 4,
    parameter int NUM_BANKS  = 4,
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input logic                   clk,
    input logic                   reset,
    banked_shared_memory_if.slave bus
);
    localparam int LOG_B     = $clog2(NUM_BANKS);
    localparam int BANK_BITS = (NUM_BANKS > 1) ? LOG_B : 1;
    localparam int ROWS      = DEPTH / NUM_BANKS;
    localparam int ROW_BITS  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SUM_W     = CNT_WIDTH + $clog2(NUM_PORTS + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

    logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][ROWS];
    logic [PTR_W-1:0]      rr_ptr_q [NUM_BANKS];
    logic [PTR_W-1:0]      rr_ptr_d [NUM_BANKS];
    int                    best_dist [NUM_BANKS];
    logic [NUM_PORTS-1:0]  grant;
    logic [NUM_PORTS-1:0]  in_range;
    logic [BANK_BITS-1:0]  bank_sel [NUM_PORTS];
    logic [ROW_BITS-1:0]   row_sel [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rdata_d [NUM_PORTS];
    logic [DATA_WIDTH-1:0] resp_rdata_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]  resp_valid_q;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [SUM_W-1:0]      count_sum;

    // Priority distance of port p from the bank pointer; 0 is highest priority.
    function automatic int rr_dist(input int p, input logic [PTR_W-1:0] ptr);
        return (p + NUM_PORTS - int'(ptr)) % NUM_PORTS;
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bank_sel[p] = BANK_BITS'(32'(bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]) % NUM_BANKS);
            row_sel[p]  = ROW_BITS'(bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH] >> LOG_B);
            in_range[p] = 32'(bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]) < DEPTH;
            rdata_d[p]  = in_range[p] ? mem_q[bank_sel[p]][row_sel[p]] : '0;
        end
    end

    always_comb begin
        grant = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            best_dist[b] = NUM_PORTS;
            rr_ptr_d[b]  = rr_ptr_q[b];
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bus.req_valid[p] && bank_sel[p] == BANK_BITS'(b)
                    && rr_dist(p, rr_ptr_q[b]) < best_dist[b]) begin
                    best_dist[b] = rr_dist(p, rr_ptr_q[b]);
                end
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bus.req_valid[p] && bank_sel[p] == BANK_BITS'(b)
                    && rr_dist(p, rr_ptr_q[b]) == best_dist[b]) begin
                    grant[p]    = 1'b1;
                    rr_ptr_d[b] = PTR_W'((p + 1) % NUM_PORTS);
                end
            end
        end
        if (reset) begin
            grant = '0;
        end
    end

    always_comb begin
        count_sum = SUM_W'(count_q);
        for (int p = 0; p < NUM_PORTS; p++) begin
            count_sum = count_sum + SUM_W'(bus.req_valid[p] & ~grant[p]);
        end
        count_d = (count_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : count_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_q[b] <= '0;
                for (int r = 0; r < ROWS; r++) begin
                    mem_q[b][r] <= '0;
                end
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                resp_rdata_q[p] <= '0;
            end
            resp_valid_q <= '0;
            count_q      <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_q[b] <= rr_ptr_d[b];
            end
            // One grant per bank means writes and reads never collide on a bank.
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant[p]) begin
                    if (bus.req_write[p]) begin
                        if (in_range[p]) begin
                            mem_q[bank_sel[p]][row_sel[p]] <= bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end else begin
                        resp_rdata_q[p] <= rdata_d[p];
                    end
                end
            end
            resp_valid_q <= grant & ~bus.req_write;
            count_q      <= count_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.resp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = resp_rdata_q[p];
        end
    end

    assign bus.req_ready      = grant;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.conflict_count = count_q;
endmodule

// File: tb/tb_banked_shared_memory.sv
// tb/tb_banked_shared_memory.sv - vector, corner-case and randomized model checks for banked_shared_memory
module tb_banked_shared_memory;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    banked_shared_memory_if #(.NUM_PORTS(4), .DATA_WIDTH(8), .ADDR_WIDTH(6), .CNT_WIDTH(16)) ifa ();
    banked_shared_memory_if #(.NUM_PORTS(4), .DATA_WIDTH(8), .ADDR_WIDTH(6), .CNT_WIDTH(2))  ifb ();

    banked_shared_memory #(.NUM_PORTS(4), .NUM_BANKS(4), .DEPTH(64), .DATA_WIDTH(8),
                           .ADDR_WIDTH(6), .CNT_WIDTH(16))
        dut_a (.clk(clk), .reset(rst_a), .bus(ifa));

    banked_shared_memory #(.NUM_PORTS(4), .NUM_BANKS(4), .DEPTH(48), .DATA_WIDTH(8),
                           .ADDR_WIDTH(6), .CNT_WIDTH(2))
        dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [23:0] pa(input int a0, input int a1, input int a2, input int a3);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    function automatic logic [31:0] pd(input int d0, input int d1, input int d2, input int d3);
        return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endfunction

    task automatic drive_a(input logic [3:0] v, input logic [3:0] w, input logic [23:0] a, input logic [31:0] d);
        ifa.req_valid = v; ifa.req_write = w; ifa.req_addr = a; ifa.req_wdata = d;
    endtask

    task automatic drive_b(input logic [3:0] v, input logic [3:0] w, input logic [23:0] a, input logic [31:0] d);
        ifb.req_valid = v; ifb.req_write = w; ifb.req_addr = a; ifb.req_wdata = d;
    endtask

    task automatic reset_a();
        drive_a(4'b0, 4'b0, '0, '0);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    typedef struct {
        string       name;
        bit          rst_before;
        logic [3:0]  valid, write;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_ready, exp_rvalid;
        logic [31:0] exp_rdata;
        int          exp_count;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input string n, input bit r, input logic [3:0] v, input logic [3:0] w,
                                input logic [23:0] a, input logic [31:0] d, input logic [3:0] er,
                                input logic [3:0] ev, input logic [31:0] ed, input int ec);
        vec_t t;
        t.name = n; t.rst_before = r; t.valid = v; t.write = w; t.addr = a; t.wdata = d;
        t.exp_ready = er; t.exp_rvalid = ev; t.exp_rdata = ed; t.exp_count = ec;
        return t;
    endfunction

    // Reference model state for the randomized phase
    int         mem_m [64];
    int         ptr_m [4];
    int         cnt_m;
    logic [7:0] rd_m [4];
    bit         pv [4];
    bit         pw [4];
    int         padr [4];
    int         pdat [4];
    int         wait_c [4];
    int         max_wait;

    initial begin
        vecs[0]  = mk("wr9_p1",   1, 4'b0010, 4'b0010, pa(0, 9, 0, 0),  pd(0, 'hA5, 0, 0), 4'b0010, 4'b0000, '0, 0);
        vecs[1]  = mk("rd9_p1",   0, 4'b0010, 4'b0000, pa(0, 9, 0, 0),  '0, 4'b0010, 4'b0010, pd(0, 'hA5, 0, 0), 0);
        vecs[2]  = mk("preload",  0, 4'b1111, 4'b1111, pa(0, 1, 2, 3),  pd('h10, 'h11, 'h12, 'h13), 4'b1111, 4'b0000, '0, 0);
        vecs[3]  = mk("par_rd",   0, 4'b1111, 4'b0000, pa(0, 1, 2, 3),  '0, 4'b1111, 4'b1111, pd('h10, 'h11, 'h12, 'h13), 0);
        vecs[4]  = mk("rr_c0",    1, 4'b1111, 4'b0000, pa(0, 4, 8, 12), '0, 4'b0001, 4'b0001, '0, 3);
        vecs[5]  = mk("rr_c1",    0, 4'b1110, 4'b0000, pa(0, 4, 8, 12), '0, 4'b0010, 4'b0010, '0, 5);
        vecs[6]  = mk("rr_c2",    0, 4'b1100, 4'b0000, pa(0, 4, 8, 12), '0, 4'b0100, 4'b0100, '0, 6);
        vecs[7]  = mk("rr_c3",    0, 4'b1000, 4'b0000, pa(0, 4, 8, 12), '0, 4'b1000, 4'b1000, '0, 6);
        vecs[8]  = mk("wrap_p3",  0, 4'b1000, 4'b0000, pa(0, 0, 0, 6),  '0, 4'b1000, 4'b1000, '0, 6);
        vecs[9]  = mk("wrap_p0",  0, 4'b1001, 4'b0001, pa(10, 0, 0, 6), pd('h77, 0, 0, 0), 4'b0001, 4'b0000, '0, 7);
        vecs[10] = mk("wrap_p3h", 0, 4'b1000, 4'b0000, pa(0, 0, 0, 6),  '0, 4'b1000, 4'b1000, '0, 7);
        vecs[11] = mk("rd10_p1",  0, 4'b0010, 4'b0000, pa(0, 10, 0, 0), '0, 4'b0010, 4'b0010, pd(0, 'h77, 0, 0), 7);

        // Reset state, with requests pending on DUT A
        rst_a = 1'b1; rst_b = 1'b1;
        drive_a(4'b1111, 4'b0, pa(0, 1, 2, 3), '0);
        drive_b(4'b0, 4'b0, '0, '0);
        #2;
        chk("rst_ready", 64'(ifa.req_ready), 64'(0));
        chk("rst_rvalid", 64'(ifa.resp_valid), 64'(0));
        chk("rst_rdata", 64'(ifa.resp_rdata), 64'(0));
        chk("rst_count", 64'(ifa.conflict_count), 64'(0));
        @(negedge clk);
        rst_b = 1'b0;
        reset_a();

        // Reset mid-run wipes storage and kills an in-flight read
        drive_a(4'b0001, 4'b0001, pa(5, 0, 0, 0), pd('h3C, 0, 0, 0));
        #1 chk("wr5_ready", 64'(ifa.req_ready), 64'(4'b0001));
        @(posedge clk); #1 chk("wr5_rvalid", 64'(ifa.resp_valid), 64'(0));
        @(negedge clk);
        drive_a(4'b0001, 4'b0000, pa(5, 0, 0, 0), '0);
        #1 chk("rd5_ready", 64'(ifa.req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        chk("rd5_rvalid", 64'(ifa.resp_valid), 64'(4'b0001));
        chk("rd5_rdata", 64'(ifa.resp_rdata[7:0]), 64'('h3C));
        @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        chk("midrst_ready", 64'(ifa.req_ready), 64'(0));
        chk("midrst_rvalid", 64'(ifa.resp_valid), 64'(0));
        chk("midrst_rdata", 64'(ifa.resp_rdata), 64'(0));
        @(posedge clk); #1 chk("midrst_lost", 64'(ifa.resp_valid), 64'(0));
        @(negedge clk);
        rst_a = 1'b0;
        #1 chk("postrst_ready", 64'(ifa.req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        chk("postrst_rvalid", 64'(ifa.resp_valid), 64'(4'b0001));
        chk("postrst_rdata", 64'(ifa.resp_rdata[7:0]), 64'(0));
        chk("postrst_count", 64'(ifa.conflict_count), 64'(0));
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].rst_before) reset_a();
            drive_a(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].wdata);
            #1 chk({vecs[i].name, "_ready"}, 64'(ifa.req_ready), 64'(vecs[i].exp_ready));
            @(posedge clk); #1;
            chk({vecs[i].name, "_rvalid"}, 64'(ifa.resp_valid), 64'(vecs[i].exp_rvalid));
            for (int p = 0; p < 4; p++) begin
                if (vecs[i].exp_rvalid[p])
                    chk({vecs[i].name, "_rdata"}, 64'(ifa.resp_rdata[p*8 +: 8]), 64'(vecs[i].exp_rdata[p*8 +: 8]));
            end
            chk({vecs[i].name, "_count"}, 64'(ifa.conflict_count), 64'(vecs[i].exp_count));
            @(negedge clk);
        end
        drive_a(4'b0, 4'b0, '0, '0);

        // DUT B: counter saturation at 3 and out-of-range accesses (DEPTH=48)
        drive_b(4'b1111, 4'b0, pa(0, 4, 8, 12), '0);
        #1 chk("sat_ready0", 64'(ifb.req_ready), 64'(4'b0001));
        @(posedge clk); #1 chk("sat_count0", 64'(ifb.conflict_count), 64'(3));
        @(negedge clk);
        drive_b(4'b1110, 4'b0, pa(0, 4, 8, 12), '0);
        #1 chk("sat_ready1", 64'(ifb.req_ready), 64'(4'b0010));
        @(posedge clk); #1 chk("sat_count1", 64'(ifb.conflict_count), 64'(3));
        @(negedge clk);
        drive_b(4'b1100, 4'b0, pa(0, 4, 8, 12), '0);
        @(posedge clk); #1 chk("sat_count2", 64'(ifb.conflict_count), 64'(3));
        @(negedge clk);
        drive_b(4'b1000, 4'b0, pa(0, 4, 8, 12), '0);
        @(posedge clk); #1;
        @(negedge clk);
        drive_b(4'b0011, 4'b0011, pa(50, 47, 0, 0), pd('hEE, 'h5A, 0, 0));
        #1 chk("oor_wr_ready", 64'(ifb.req_ready), 64'(4'b0011));
        @(posedge clk); #1 chk("oor_wr_rvalid", 64'(ifb.resp_valid), 64'(0));
        @(negedge clk);
        drive_b(4'b0011, 4'b0000, pa(50, 47, 0, 0), '0);
        #1 chk("oor_rd_ready", 64'(ifb.req_ready), 64'(4'b0011));
        @(posedge clk); #1;
        chk("oor_rd_rvalid", 64'(ifb.resp_valid), 64'(4'b0011));
        chk("oor_rd_rdata", 64'(ifb.resp_rdata[7:0]), 64'(0));
        chk("inr_rd_rdata", 64'(ifb.resp_rdata[15:8]), 64'('h5A));
        chk("sat_count3", 64'(ifb.conflict_count), 64'(3));
        @(negedge clk);
        drive_b(4'b0, 4'b0, '0, '0);

        // Randomized traffic against the reference model
        reset_a();
        for (int i = 0; i < 64; i++) mem_m[i] = 0;
        for (int i = 0; i < 4; i++) begin
            ptr_m[i] = 0; rd_m[i] = '0; pv[i] = 0; wait_c[i] = 0;
        end
        cnt_m = 0; max_wait = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [3:0] eg, erv;
            int nptr [4];
            int stalls;
            for (int p = 0; p < 4; p++) begin
                if (!pv[p] && $urandom_range(0, 3) != 0) begin
                    pv[p] = 1; pw[p] = 1'($urandom_range(0, 1));
                    padr[p] = int'($urandom_range(0, 15)); pdat[p] = int'($urandom_range(0, 255));
                end
                ifa.req_valid[p] = pv[p];
                ifa.req_write[p] = pw[p];
                ifa.req_addr[p*6 +: 6] = 6'(padr[p]);
                ifa.req_wdata[p*8 +: 8] = 8'(pdat[p]);
            end
            eg = '0;
            for (int b = 0; b < 4; b++) begin
                bit found;
                found = 0; nptr[b] = ptr_m[b];
                for (int k = 0; k < 4; k++) begin
                    int q;
                    q = (ptr_m[b] + k) % 4;
                    if (!found && pv[q] && (padr[q] % 4) == b) begin
                        found = 1; eg[q] = 1'b1; nptr[b] = (q + 1) % 4;
                    end
                end
            end
            #1 chk("rnd_ready", 64'(ifa.req_ready), 64'(eg));
            erv = '0; stalls = 0;
            for (int p = 0; p < 4; p++) begin
                if (eg[p]) begin
                    if (pw[p]) mem_m[padr[p]] = pdat[p];
                    else begin erv[p] = 1'b1; rd_m[p] = 8'(mem_m[padr[p]]); end
                end else if (pv[p]) stalls++;
                if (pv[p] && !ifa.req_ready[p]) wait_c[p]++;
                else wait_c[p] = 0;
                if (wait_c[p] > max_wait) max_wait = wait_c[p];
            end
            for (int b = 0; b < 4; b++) ptr_m[b] = nptr[b];
            cnt_m = (cnt_m + stalls > 65535) ? 65535 : cnt_m + stalls;
            @(posedge clk); #1;
            chk("rnd_rvalid", 64'(ifa.resp_valid), 64'(erv));
            chk("rnd_rdata", 64'(ifa.resp_rdata), 64'({rd_m[3], rd_m[2], rd_m[1], rd_m[0]}));
            chk("rnd_count", 64'(ifa.conflict_count), 64'(cnt_m));
            for (int p = 0; p < 4; p++) if (eg[p]) pv[p] = 0;
            @(negedge clk);
        end
        chk("rnd_fairness", 64'(max_wait < 4), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
